// File: rtl/gpr_wb_pkg.sv
// Shared types and widths for the GPR write-port arbiter and its secondary-result queue.
package gpr_wb_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned REG_DW   = 32;
    localparam int unsigned STARVE_W = 4;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [STARVE_W-1:0] starve_cnt_t;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [REG_DW-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order queue of pending register writes with kill-by-address,
// compaction of removed entries and two address-match lookups for the hazard unit.
module wb_fifo2
    import gpr_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [REG_AW-1:0] kill_wa,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic [REG_AW-1:0] q_a1,
    input  logic [REG_AW-1:0] q_a2,
    output wb_entry_t         head_c,
    output logic              empty_c,
    output logic              full_c,
    output logic              match1_c,
    output logic              match2_c
);

    wb_entry_t [1:0] ent_q;
    wb_entry_t [1:0] ent_d;
    logic      [1:0] vld_q;
    logic      [1:0] vld_d;
    logic      [1:0] keep;
    logic            push_ok;

    // Entries are kept compacted: slot 1 valid implies slot 0 valid.
    always_comb begin
        ent_d   = ent_q;
        vld_d   = 2'b00;
        keep[0] = vld_q[0] && !pop && !(kill_en && (ent_q[0].wa == kill_wa));
        keep[1] = vld_q[1] && !(kill_en && (ent_q[1].wa == kill_wa));
        push_ok = push && !vld_q[1];

        if (keep[0]) begin
            vld_d[0] = 1'b1;
            if (keep[1]) begin
                vld_d[1] = 1'b1;
            end else if (push_ok) begin
                ent_d[1] = push_entry;
                vld_d[1] = 1'b1;
            end
        end else if (keep[1]) begin
            ent_d[0] = ent_q[1];
            vld_d[0] = 1'b1;
            if (push_ok) begin
                ent_d[1] = push_entry;
                vld_d[1] = 1'b1;
            end
        end else if (push_ok) begin
            ent_d[0] = push_entry;
            vld_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q <= '0;
            vld_q <= 2'b00;
        end else begin
            ent_q <= ent_d;
            vld_q <= vld_d;
        end
    end

    always_comb begin
        head_c   = ent_q[0];
        empty_c  = !vld_q[0];
        full_c   = vld_q[1];
        match1_c = (q_a1 != REG_ZERO) &&
                   ((vld_q[0] && (ent_q[0].wa == q_a1)) || (vld_q[1] && (ent_q[1].wa == q_a1)));
        match2_c = (q_a2 != REG_ZERO) &&
                   ((vld_q[0] && (ent_q[0].wa == q_a2)) || (vld_q[1] && (ent_q[1].wa == q_a2)));
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Sole owner of the register-file write port: W-stage writes win, queued secondary results drain otherwise.
// Define GPR_WB_TRACE_EN to print a register-write / drop trace for log diffing.
module gpr_write_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              p_we,
    input  logic [REG_AW-1:0] p_wa,
    input  logic [REG_DW-1:0] p_wd,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [REG_AW-1:0] s_wa,
    input  logic [REG_DW-1:0] s_wd,
    input  logic [REG_AW-1:0] q_a1,
    input  logic [REG_AW-1:0] q_a2,
    output logic              pend1,
    output logic              pend2,
    output logic              gpr_we,
    output logic [REG_AW-1:0] gpr_wa,
    output logic [REG_DW-1:0] gpr_wd,
    output logic              stall_o
);

    logic              prim_act;
    logic              drain;
    logic              push;
    logic              q_empty;
    logic              q_full;
    logic              match1;
    logic              match2;
    wb_entry_t         head;
    wb_entry_t         push_entry;
    starve_cnt_t       cnt_q;
    starve_cnt_t       cnt_d;
    logic [REG_AW-1:0] last_wa_q;
    logic [REG_AW-1:0] last_wa_d;
    logic [REG_DW-1:0] last_wd_q;
    logic [REG_DW-1:0] last_wd_d;

    wb_fifo2 u_fifo (
        .clk        (clk),
        .reset      (reset),
        .pop        (drain),
        .kill_en    (prim_act),
        .kill_wa    (p_wa),
        .push       (push),
        .push_entry (push_entry),
        .q_a1       (q_a1),
        .q_a2       (q_a2),
        .head_c     (head),
        .empty_c    (q_empty),
        .full_c     (q_full),
        .match1_c   (match1),
        .match2_c   (match2)
    );

    // Queued results are older than a concurrent primary write to the same register, so they are dropped.
    always_comb begin
        prim_act      = !reset && p_we && (p_wa != REG_ZERO);
        drain         = !reset && !prim_act && !q_empty;
        push          = s_valid && !q_full && (s_wa != REG_ZERO) && !(prim_act && (s_wa == p_wa));
        push_entry.wa = s_wa;
        push_entry.wd = s_wd;

        gpr_we = prim_act || drain;
        gpr_wa = last_wa_q;
        gpr_wd = last_wd_q;
        if (prim_act) begin
            gpr_wa = p_wa;
            gpr_wd = p_wd;
        end else if (drain) begin
            gpr_wa = head.wa;
            gpr_wd = head.wd;
        end
        last_wa_d = gpr_wa;
        last_wd_d = gpr_wd;

        cnt_d = cnt_q;
        if (q_empty || drain) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + starve_cnt_t'(1);
        end

        s_ready = !q_full;
        stall_o = q_full || (cnt_q >= starve_cnt_t'(STARVE_MAX));
        pend1   = match1;
        pend2   = match2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            last_wa_q <= '0;
            last_wd_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            last_wa_q <= last_wa_d;
            last_wd_q <= last_wd_d;
        end
    end

`ifdef GPR_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (gpr_we && (gpr_wa != REG_ZERO)) begin
            $display("$%0d <= %08h", gpr_wa, gpr_wd);
        end
        if (!reset && s_valid && s_ready && !push) begin
            $display("drop $%0d", s_wa);
        end
        for (int i = 0; i < 2; i++) begin
            if (prim_act && u_fifo.vld_q[i] && (u_fifo.ent_q[i].wa == p_wa)) begin
                $display("drop $%0d", p_wa);
            end
        end
    end
`endif

endmodule
